// File: rtl/enemy_fire_ctrl.sv
// Enemy shot scheduler: waits a fixed period, picks a pseudo-random column and fires
// from the lowest living enemy in it, then waits for the munition to report busy.
module enemy_fire_ctrl #(
    parameter int          LINHAS    = 1,
    parameter int          COLUNAS   = 2,
    parameter int          PERIODO   = 5_000_000,
    parameter int          HOLD_MAX  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [LINHAS*COLUNAS-1:0] vivo_inimigo,
    input  logic                      shot_busy,
    output logic                      shot_req,
    output logic [9:0]                ID_enemy_tiro_X,
    output logic [9:0]                ID_enemy_tiro_Y
);

    localparam int CW = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
    localparam int SW = $clog2(COLUNAS + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {StIdle, StWait, StPick, StFire, StHold} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_timer, w_timer_nxt;
    logic [15:0]   r_lfsr, w_lfsr_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [SW-1:0] r_scan, w_scan_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [9:0]    r_id_x, w_id_x_nxt;
    logic [9:0]    r_id_y, w_id_y_nxt;

    logic          w_hit;
    logic [9:0]    w_hit_x;
    logic [9:0]    w_hit_y;
    logic [CW-1:0] w_lfsr_col;

    // Ascending row scan: the last match is the highest row, i.e. lowest on screen.
    always_comb begin
        w_hit   = 1'b0;
        w_hit_x = '0;
        w_hit_y = '0;
        for (int k = 0; k < LINHAS; k++) begin
            for (int c = 0; c < COLUNAS; c++) begin
                if (r_col == CW'(c) && vivo_inimigo[k*COLUNAS+c]) begin
                    w_hit   = 1'b1;
                    w_hit_x = 10'(k * COLUNAS + c);
                    w_hit_y = 10'(k);
                end
            end
        end
    end

    always_comb begin
        w_lfsr_col  = CW'(32'(r_lfsr) % 32'(COLUNAS));
        w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_col_nxt   = r_col;
        w_scan_nxt  = r_scan;
        w_hold_nxt  = r_hold;
        w_id_x_nxt  = r_id_x;
        w_id_y_nxt  = r_id_y;
        if (!enable) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_nxt = StWait;
                    w_timer_nxt = 32'(PERIODO - 1);
                end
                StWait: begin
                    if (r_timer != 32'd0) begin
                        w_timer_nxt = r_timer - 32'd1;
                    end else if (!shot_busy) begin
                        w_state_nxt = StPick;
                        w_col_nxt   = w_lfsr_col;
                        w_scan_nxt  = '0;
                    end
                end
                StPick: begin
                    if (w_hit) begin
                        w_state_nxt = StFire;
                        w_id_x_nxt  = w_hit_x;
                        w_id_y_nxt  = w_hit_y;
                    end else if (r_scan == SW'(COLUNAS - 1)) begin
                        w_state_nxt = StWait;
                        w_timer_nxt = 32'(PERIODO - 1);
                    end else begin
                        w_col_nxt  = (r_col == CW'(COLUNAS - 1)) ? '0 : r_col + 1'b1;
                        w_scan_nxt = r_scan + 1'b1;
                    end
                end
                StFire: begin
                    w_state_nxt = StHold;
                    w_hold_nxt  = '0;
                end
                StHold: begin
                    if (shot_busy || r_hold == HW'(HOLD_MAX - 1)) begin
                        w_state_nxt = StWait;
                        w_timer_nxt = 32'(PERIODO - 1);
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_timer <= 32'd0;
            r_lfsr  <= LFSR_SEED;
            r_col   <= '0;
            r_scan  <= '0;
            r_hold  <= '0;
            r_id_x  <= '0;
            r_id_y  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_col   <= w_col_nxt;
            r_scan  <= w_scan_nxt;
            r_hold  <= w_hold_nxt;
            r_id_x  <= w_id_x_nxt;
            r_id_y  <= w_id_y_nxt;
        end
    end

    // Gated by reset so an in-cycle reset during FIRE suppresses the pulse.
    assign shot_req        = (r_state == StFire) && enable && !reset;
    assign ID_enemy_tiro_X = r_id_x;
    assign ID_enemy_tiro_Y = r_id_y;

endmodule

// File: tb/tb_enemy_fire_ctrl.sv
// Directed bench for enemy_fire_ctrl: period timing, column choice, busy handshake,
// hold timeout and enable abort.
module tb_enemy_fire_ctrl;

    localparam int          LINHAS   = 2;
    localparam int          COLUNAS  = 3;
    localparam int          PERIODO  = 8;
    localparam int          HOLD_MAX = 4;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [5:0] vivo;
    logic       shot_busy;
    logic       shot_req;
    logic [9:0] id_x;
    logic [9:0] id_y;

    enemy_fire_ctrl #(
        .LINHAS   (LINHAS),
        .COLUNAS  (COLUNAS),
        .PERIODO  (PERIODO),
        .HOLD_MAX (HOLD_MAX),
        .LFSR_SEED(SEED)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .vivo_inimigo   (vivo),
        .shot_busy      (shot_busy),
        .shot_req       (shot_req),
        .ID_enemy_tiro_X(id_x),
        .ID_enemy_tiro_Y(id_y)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, same reset/advance rule as the shooter selector.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    logic [15:0] h0, h1, h2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; h2 holds the LFSR value from two cycles back.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        h2 = h1;
        h1 = h0;
        h0 = m_lfsr;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        shot_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] exp_x(input logic [15:0] l);
        return 32'd3 + (32'(l) % 32'd3);
    endfunction

    int          seen;
    int          last;
    int          nshots;
    bit          pend;
    logic [31:0] last_x;

    initial begin
        vivo = 6'h3F;
        do_reset();
        chk("rst_req", shot_req, 0);
        chk("rst_idx", id_x, 0);
        chk("rst_idy", id_y, 0);

        // Disabled: never fires.
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (shot_req) seen++;
        end
        chk("idle_req", seen, 0);
        chk("idle_idx", id_x, 0);
        chk("idle_idy", id_y, 0);

        // All alive: first shot at cycle 10 from the bottom row.
        do_reset();
        enable = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_req", shot_req, cyc == 10);
            if (cyc == 10) begin
                chk("t2_idx", id_x, exp_x(h2));
                chk("t2_idy", id_y, 1);
            end
        end

        // Only index 1 alive, busy acknowledged one cycle after each shot.
        do_reset();
        vivo   = 6'b000010;
        enable = 1'b1;
        cyc    = 0;
        last   = -1;
        nshots = 0;
        pend   = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            shot_busy = pend;
            pend      = 1'b0;
            if (shot_req) begin
                chk("t3_idx", id_x, 1);
                chk("t3_idy", id_y, 0);
                if (last >= 0)
                    chk("t3_space", (cyc - last >= 11) && (cyc - last <= 13), 1);
                last = cyc;
                nshots++;
                pend = 1'b1;
            end
        end
        shot_busy = 1'b0;
        chk("t3_nshots", nshots >= 8, 1);

        // Nobody alive: no shots.
        do_reset();
        vivo   = 6'b0;
        enable = 1'b1;
        seen   = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (shot_req) seen++;
        end
        chk("t4_req", seen, 0);
        chk("t4_idx", id_x, 0);

        // Busy held across expiry, released at cycle 50.
        do_reset();
        vivo      = 6'h3F;
        shot_busy = 1'b1;
        enable    = 1'b1;
        cyc       = 0;
        seen      = 0;
        for (int i = 0; i < 55; i++) begin
            tick();
            if (cyc == 50) shot_busy = 1'b0;
            if (cyc < 48) begin
                if (shot_req) seen++;
            end else begin
                chk("t5_req", shot_req, cyc == 52);
                if (cyc == 52) chk("t5_idx", id_x, exp_x(h2));
            end
        end
        chk("t5_early", seen, 0);

        // No acknowledge: 4 HOLD cycles, then a drop of enable during PICK.
        do_reset();
        vivo   = 6'h3F;
        enable = 1'b1;
        cyc    = 0;
        last_x = 0;
        for (int i = 0; i < 51; i++) begin
            tick();
            chk("t6_req", shot_req, cyc == 10 || cyc == 24 || cyc == 38);
            if (shot_req) begin
                last_x = exp_x(h2);
                chk("t6_idx", id_x, last_x);
            end
        end
        enable = 1'b0;
        chk("t6_pick_req", shot_req, 0);
        seen = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (shot_req) seen++;
        end
        chk("t6_abort_req", seen, 0);
        chk("t6_hold_idx", id_x, last_x);
        chk("t6_hold_idy", id_y, 1);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t6_reen_req", shot_req, cyc == 80);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enemy_fire_ctrl.md
# enemy_fire_ctrl

Enemy shot scheduler and shooter selector. It consumes the enemy-alive vector and the enemy munition's busy flag. It produces a one-cycle launch request plus the flat index and row of the enemy that fires. The top level uses those indices to look up the shooter's X/Y position for the enemy munition. It replaces the constant shooter IDs with a timed, pseudo-random choice of the lowest living enemy in a column.

## Interface

Parameters:
- LINHAS, 1: enemy rows.
- COLUNAS, 2: enemy columns.
- PERIODO, 5_000_000: minimum clk cycles between shots (≥2).
- HOLD_MAX, 16: cycles to wait for shot_busy acknowledge.
- LFSR_SEED, 16'hACE1: LFSR reset value (nonzero).

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: game running (game state 1); low forces IDLE.
- vivo_inimigo, in, LINHAS*COLUNAS: alive flags, flat index k*COLUNAS+c.
- shot_busy, in, 1: enemy munition in flight.
- shot_req, out, 1: one-cycle launch pulse.
- ID_enemy_tiro_X, out, 10: flat index of shooter.
- ID_enemy_tiro_Y, out, 10: row index of shooter.

## Operation

- States: IDLE, WAIT, PICK, FIRE, HOLD. All registered.
- LFSR: 16-bit Galois with mask 16'hB400, shift right. It advances every non-reset cycle in all states.
- IDLE:
  - shot_req=0.
  - If enable=1: go to WAIT and load timer=PERIODO-1.
- WAIT:
  - Timer decrements each cycle.
  - If timer==0 and shot_busy==0: go to PICK and latch col=lfsr%COLUNAS. The lfsr value used is the one in the transition cycle.
  - If timer==0 and shot_busy==1: hold timer at 0 and stay in WAIT.
- PICK: one column examined per cycle.
  - Shooter is the highest row k with vivo_inimigo[k*COLUNAS+col]=1 (lowest on screen).
  - If found: latch ID_enemy_tiro_X=k*COLUNAS+col and ID_enemy_tiro_Y=k, then go to FIRE.
  - Otherwise: col=(col+1) wraps to 0 at COLUNAS.
  - After COLUNAS empty columns: go to WAIT and reload timer (no shot).
- FIRE: shot_req=1 for exactly this cycle, then go to HOLD.
- HOLD:
  - If shot_busy==1, or HOLD_MAX cycles have elapsed in HOLD: go to WAIT and reload timer=PERIODO-1.
- enable=0 in any state: go to IDLE next cycle. shot_req is forced 0 combinationally. IDs are held.
- ID outputs change only on a PICK hit. They are stable from FIRE until the next hit.
- Alive vector is sampled live in PICK. A kill during PICK affects only the columns not yet scanned.
- Widths:
  - Timer: 32 bits.
  - Column and HOLD counters: ≥ clog2 of their limits.
  - ID outputs are zero-extended.

## Timing

- Reset values:
  - State: IDLE.
  - shot_req: 0.
  - ID_enemy_tiro_X, ID_enemy_tiro_Y: 0.
  - LFSR: LFSR_SEED.
  - Timer: 0.
- Reset has priority over everything. Reset mid-PICK or mid-FIRE aborts with no pulse.
- enable high sampled at cycle t: WAIT covers t+1..t+PERIODO, then PICK.
- Latency from the timer==0 cycle to shot_req is 2 cycles on a first-column hit. Each empty column scanned adds 1 cycle. Worst case is COLUNAS+1.
- Shot spacing is ≥ PERIODO+3 cycles. Between shots there is no second shot_req without a return through WAIT.
- shot_busy falling while the timer is expired: PICK starts the next cycle.

## Test plan

Bench configuration: LINHAS=2, COLUNAS=3, PERIODO=8, HOLD_MAX=4, seed 16'hACE1.

- Reset then enable=0 for 200 cycles -> shot_req never 1; IDs 0.
- All alive, enable rises at cycle 0 with shot_busy=0 -> shot_req high only at cycle 10. ID_Y=1. ID_X=3+(lfsr%3), where lfsr is the model value at cycle 8.
- Only flat index 1 alive, shot_busy pulsed one cycle after each FIRE -> every shot has ID_X=1, ID_Y=0. Spacing between shots is PERIODO+3..PERIODO+5 cycles.
- vivo_inimigo=0 for 1000 cycles -> no shot_req. The FSM loops WAIT↔PICK, with PICK lasting 3 cycles.
- shot_busy held 1 across timer expiry, released at cycle 50 -> shot_req at cycle 52. No pulse before.
- shot_busy never rises after FIRE -> WAIT re-entered after 4 HOLD cycles. Separately, dropping enable during PICK -> IDLE next cycle with no shot_req.
